// File: rtl/uart_tx_arbiter.sv
// Purpose: packet-granular round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Latency: a request seen in IDLE launches on the next cycle when the transmitter is idle; bytes >= 2 cycles apart.
// Backpressure: holds in SEND while uart_tx_busy is high; one byte in flight, req_ready is the per-byte accept.
//
// Ports:
//   clk, resetn            system clock, synchronous active-low reset
//   req_valid/last/data    per-requester byte stream; data of requester i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   req_ready              one-hot, one-cycle accept of the granted requester's byte
//   uart_tx_en/data        one-cycle launch strobe and byte to the transmitter
//   uart_tx_busy           transmitter busy; rises at the latest the cycle after launch
//   grant_id, grant_active current (or last) granted requester, packet in progress
//   timeout_pulse          one-cycle flag when a stalled grant is forcibly released
//
// Optional feature: define UART_ARB_TIMEOUT_EN to build the mid-packet stall timeout
// (TIMEOUT_CYCLES). Without it, timeout_pulse is tied low and SEND waits forever.

module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int PAYLOAD_BITS   = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
  input  logic                            uart_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            grant_active,
  output logic                            timeout_pulse
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Reject configurations the arbiter is not meant to support at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 8 || PAYLOAD_BITS < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_GUARD = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic            last_q;      // req_last of the byte currently in the transmitter

  logic            gnt_valid;
  logic            accept;
  logic [ID_W-1:0] grant_next;
  logic            pick_found;
  logic [ID_W-1:0] pick_id;
  logic [ID_W-1:0] scan_idx;

  // (base + k) mod NUM_REQ without relying on NUM_REQ being a power of two.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  assign gnt_valid  = req_valid[grant_id];
  assign grant_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  // A byte transfers only in SEND, with the granted requester valid and the transmitter free.
  assign accept     = (state == ST_SEND) && gnt_valid && !uart_tx_busy;

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = wrap_add(rr_ptr, k);
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  // Launch-side outputs are decoded from registered state so the accept and
  // the launch land in the same cycle; everything is zero outside an accept.
  always_comb begin
    req_ready    = '0;
    uart_tx_en   = accept;
    uart_tx_data = '0;
    if (accept) begin
      req_ready[grant_id] = 1'b1;
      uart_tx_data        = req_data[grant_id*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] stall_cnt;   // SEND cycles spent with the granted requester not valid
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      // Mid-packet reset abandons the packet; a byte already launched is not tracked.
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      last_q       <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      stall_cnt     <= '0;
      timeout_pulse <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      timeout_pulse <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id     <= pick_id;
            grant_active <= 1'b1;
            state        <= ST_SEND;
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt    <= '0;
`endif
          end
        end

        ST_SEND: begin
          if (accept) begin
            last_q <= req_last[grant_id];
            state  <= ST_GUARD;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (!gnt_valid) begin
            // Busy-only waits do not count; only a silent granted requester does.
            if (stall_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
              timeout_pulse <= 1'b1;
              rr_ptr        <= grant_next;
              grant_active  <= 1'b0;
              state         <= ST_IDLE;
            end else begin
              stall_cnt <= stall_cnt + TO_W'(1);
            end
          end
`endif
        end

        // The transmitter may raise busy one cycle after launch; skip that cycle
        // so DRAIN never mistakes the pre-rise low for completion.
        ST_GUARD: state <= ST_DRAIN;

        ST_DRAIN: begin
          if (!uart_tx_busy) begin
            if (last_q) begin
              rr_ptr       <= grant_next;
              grant_active <= 1'b0;
              state        <= ST_IDLE;
            end else begin
              state <= ST_SEND;
`ifdef UART_ARB_TIMEOUT_EN
              stall_cnt <= '0;
`endif
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef UART_ARB_TIMEOUT_EN
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-granular round-robin arbiter that shares one UART transmitter among `NUM_REQ` requesters. It sits between several byte-stream producers, such as a command responder, a debug logger or a status reporter, and the single `uart_tx` instance. Each packet runs from the first byte through the byte flagged `last` and is sent without interleaving from other requesters. Grant rotates fairly once a packet ends.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `PAYLOAD_BITS`, 8, byte width; matches the UART payload width
- `TIMEOUT_CYCLES`, 1024, mid-packet stall limit (used only with `UART_ARB_TIMEOUT_EN`)

- `clk`  in  1  system clock
- `resetn`  in  1  synchronous, active-low reset
- `req_valid`  in  NUM_REQ  requester i has a byte pending
- `req_last`  in  NUM_REQ  pending byte of requester i ends its packet
- `req_data`  in  NUM_REQ*PAYLOAD_BITS  byte of requester i, at bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept of requester i's byte
- `uart_tx_en`  out  1  one-cycle launch strobe to the transmitter
- `uart_tx_data`  out  PAYLOAD_BITS  byte launched with `uart_tx_en`
- `uart_tx_busy`  in  1  transmitter busy; rises at the latest the cycle after launch
- `grant_id`  out  clog2(NUM_REQ)  current or last granted requester
- `grant_active`  out  1  a packet is in progress
- `timeout_pulse`  out  1  one-cycle flag: grant forcibly released

## Operation
- States: IDLE, SEND, GUARD, DRAIN.
- **IDLE:**
  - If any `req_valid` is set, pick the first set index searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - Register that index into `grant_id`, set `grant_active`, go to SEND.
- **SEND:**
  - When `req_valid[grant_id]` and `!uart_tx_busy`, assert `uart_tx_en=1` and `req_ready[grant_id]=1` in the same cycle.
  - Drive `uart_tx_data` from `req_data[grant_id]`.
  - Latch `req_last[grant_id]`, go to GUARD.
- **GUARD:** one cycle to absorb the transmitter's busy-rise latency; go to DRAIN.
- **DRAIN:**
  - Wait for `!uart_tx_busy`.
  - If the latched `last` is set: `rr_ptr <= grant_id+1` (mod NUM_REQ), clear `grant_active`, go to IDLE.
  - Otherwise return to SEND.
- The handshake is a transfer only when `req_ready[i]=1`. Requesters must hold `req_valid`, `req_last` and `req_data` stable until accepted.
- Outside a SEND-accept cycle, `req_ready`, `uart_tx_en` and `uart_tx_data` are 0. These outputs are decoded combinationally from the registered state.
- Non-granted requesters are ignored during a packet. Their valid lines raised mid-packet only count at the next IDLE.
- A single-byte packet has `req_last=1` on its first byte.
- A requester that deasserts `req_valid` mid-packet keeps the grant; SEND waits indefinitely unless timeout is compiled in.
- Reset mid-packet: return to IDLE immediately and set `rr_ptr=0`. No partial byte is re-sent. A byte already launched completes inside the transmitter and is not tracked.

## Timing
- Reset values: state IDLE, `rr_ptr=0`, `grant_id=0`, `grant_active=0`. Outputs `req_ready=0`, `uart_tx_en=0`, `uart_tx_data=0`, `timeout_pulse=0`.
- First byte latency: `req_valid` seen in IDLE at cycle N gives SEND at N+1. `uart_tx_en` fires at N+1 if the transmitter is idle.
- Minimum spacing between launches is 2 cycles (GUARD, then DRAIN seeing not-busy) plus the transmitter busy time.
- Grant rotation happens in the DRAIN exit cycle. A new arbitration decision follows one cycle later in IDLE.
- With all requesters valid continuously, grants go 0,1,2,3,0,... one full packet each.

## Configuration
- Macro `UART_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on every entry to SEND and increments each SEND cycle in which `req_valid[grant_id]=0`.
  - At the cycle the counter reaches `TIMEOUT_CYCLES-1`: `timeout_pulse=1` for one cycle, `rr_ptr <= grant_id+1`, `grant_active <= 0`, state goes to IDLE.
- **Undefined:** no counter is built, `timeout_pulse` is tied to 0, and SEND waits forever.

## Test plan
- **Single-byte packet:** reset, requester 2 sends `0xA5` with `last=1` → `uart_tx_en` at cycle N+1 with `uart_tx_data=0xA5`, `req_ready=4'b0100`, `grant_id=2`, return to IDLE after busy falls.
- **No interleaving:** requester 0 sends 3-byte packet `0x11,0x22,0x33` while requester 1 holds `0x44` valid → transmit order 11,22,33,44; `req_ready[1]` stays low until the byte `0x33` drains.
- **Fairness:** all 4 requesters continuously valid with 1-byte packets, 8 packets → grant order 0,1,2,3,0,1,2,3.
- **Busy backpressure:** hold `uart_tx_busy=1` for 100 cycles with requester 1 valid → no `uart_tx_en` and no `req_ready`; launch happens the first cycle busy is low.
- **Timeout (macro on, TIMEOUT_CYCLES=16):** requester 3 sends a first byte with `last=0` then drops valid → `timeout_pulse` 16 cycles after SEND re-entry, next grant goes to requester 0. With the macro off → no pulse, grant held.
- **Reset mid-packet:** assert `resetn=0` during DRAIN of byte 2 of 4 → all outputs at reset values next cycle, `grant_active=0`, and after release requester 0 wins arbitration from `rr_ptr=0`.
